// File: rtl/parking_gate_controller_pkg.sv
// rtl/parking_gate_controller_pkg.sv - shared state encoding and defaults for the parking gate controller
package parking_gate_controller_pkg;

    localparam logic [15:0] PIN_DEFAULT          = 16'h5990;
    localparam int          MAX_ATTEMPTS_DEFAULT = 3;
    localparam int          CNT_W                = 2;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_PIN    = 3'd1,
        ST_OPEN        = 3'd2,
        ST_ALARM_PIN   = 3'd3,
        ST_ALARM_BLOCK = 3'd4
    } state_t;

endpackage

// File: rtl/parking_gate_controller_ack_edge_detect.sv
// rtl/parking_gate_controller_ack_edge_detect.sv - rising-edge detector for the code acknowledge strobe
module ack_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic r_in_q;

    // Clearing to 0 in reset is safe: the FSM sits in IDLE on the first edge, where a rise is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_q <= 1'b0;
        end else begin
            r_in_q <= in;
        end
    end

    assign rise = in & ~r_in_q;

endmodule

// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - PIN-guarded parking gate FSM with attempt counter and alarms
module parking_gate_controller
    import parking_gate_controller_pkg::*;
#(
    parameter logic [15:0] PIN          = PIN_DEFAULT,
    parameter int          MAX_ATTEMPTS = MAX_ATTEMPTS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vehicle_arrival,
    input  logic        vehicle_left,
    input  logic [15:0] code,
    input  logic        code_ack,
    output logic        gate_open,
    output logic        gate_close,
    output logic        wrong_pin,
    output logic        pin_alarm,
    output logic        block_alarm
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ATTEMPTS);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_attempts;
    logic [CNT_W-1:0]   w_next_attempts;
    logic [CNT_W-1:0]   w_attempts_inc;
    logic               w_ack_rise;
    logic               w_code_ok;
    logic               w_accept;
    logic               w_wrong;
    logic               r_gate_open;
    logic               r_gate_close;
    logic               r_wrong_pin;
    logic               r_pin_alarm;
    logic               r_block_alarm;

    ack_edge_detect u_ack_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (code_ack),
        .rise (w_ack_rise)
    );

    assign w_code_ok      = (code == PIN);
    assign w_accept       = w_ack_rise & w_code_ok;
    assign w_attempts_inc = (r_attempts == {CNT_W{1'b1}}) ? r_attempts : r_attempts + 1'b1;

    always_comb begin
        w_next_state    = r_state;
        w_next_attempts = r_attempts;
        w_wrong         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (vehicle_arrival) begin
                    w_next_state = ST_WAIT_PIN;
                end
            end
            ST_WAIT_PIN: begin
                if (w_accept) begin
                    w_next_state    = ST_OPEN;
                    w_next_attempts = '0;
                end else if (w_ack_rise) begin
                    w_wrong         = 1'b1;
                    w_next_attempts = w_attempts_inc;
                    if (w_attempts_inc >= MAX_CNT) begin
                        w_next_state = ST_ALARM_PIN;
                    end
                end
            end
            ST_OPEN: begin
                // A second vehicle at the entry outranks the exit sensor.
                if (vehicle_arrival && vehicle_left) begin
                    w_next_state = ST_ALARM_BLOCK;
                end else if (vehicle_left) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ALARM_PIN: begin
                if (w_accept) begin
                    w_next_state    = ST_OPEN;
                    w_next_attempts = '0;
                end
            end
            ST_ALARM_BLOCK: begin
                if (w_accept) begin
                    w_next_state    = ST_OPEN;
                    w_next_attempts = '0;
                end
            end
            default: begin
                w_next_state    = ST_IDLE;
                w_next_attempts = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they appear on the same edge as the state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_attempts    <= '0;
            r_gate_open   <= 1'b0;
            r_gate_close  <= 1'b1;
            r_wrong_pin   <= 1'b0;
            r_pin_alarm   <= 1'b0;
            r_block_alarm <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_attempts    <= w_next_attempts;
            r_gate_open   <= (w_next_state == ST_OPEN);
            r_gate_close  <= (w_next_state != ST_OPEN);
            r_wrong_pin   <= w_wrong;
            r_pin_alarm   <= (w_next_state == ST_ALARM_PIN);
            r_block_alarm <= (w_next_state == ST_ALARM_BLOCK);
        end
    end

    assign gate_open   = r_gate_open;
    assign gate_close  = r_gate_close;
    assign wrong_pin   = r_wrong_pin;
    assign pin_alarm   = r_pin_alarm;
    assign block_alarm = r_block_alarm;

endmodule

// File: tb/tb_parking_gate_controller.sv
// tb/tb_parking_gate_controller.sv - directed and randomized checks of parking_gate_controller against a behavioural model
module tb_parking_gate_controller;

    localparam logic [15:0] PIN = 16'h5990;
    localparam int MAX_TRIES = 3;

    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_OPEN  = 2;
    localparam int M_APIN  = 3;
    localparam int M_ABLK  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vehicle_arrival = 1'b0;
    logic        vehicle_left = 1'b0;
    logic [15:0] code = 16'h0000;
    logic        code_ack = 1'b0;
    logic        gate_open, gate_close, wrong_pin, pin_alarm, block_alarm;

    int checks = 0;
    int errors = 0;

    int m_mode  = M_IDLE;
    int m_tries = 0;
    bit m_prev_ack = 1'b0;
    bit m_wp = 1'b0;

    parking_gate_controller #(.PIN(PIN), .MAX_ATTEMPTS(MAX_TRIES)) dut (
        .clk             (clk),
        .rst             (rst),
        .vehicle_arrival (vehicle_arrival),
        .vehicle_left    (vehicle_left),
        .code            (code),
        .code_ack        (code_ack),
        .gate_open       (gate_open),
        .gate_close      (gate_close),
        .wrong_pin       (wrong_pin),
        .pin_alarm       (pin_alarm),
        .block_alarm     (block_alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
        end
    endtask

    // One rising-edge step of the behavioural model, from the current input values.
    task automatic model_step();
        bit rise;
        bit good;
        if (!rst) begin
            m_mode = M_IDLE; m_tries = 0; m_prev_ack = 1'b0; m_wp = 1'b0;
            return;
        end
        rise = code_ack && !m_prev_ack;
        good = (code == PIN);
        m_wp = 1'b0;
        case (m_mode)
            M_IDLE: if (vehicle_arrival) m_mode = M_WAIT;
            M_WAIT: if (rise) begin
                if (good) begin
                    m_mode = M_OPEN; m_tries = 0;
                end else begin
                    m_wp = 1'b1;
                    m_tries = (m_tries + 1 > 3) ? 3 : m_tries + 1;
                    if (m_tries >= MAX_TRIES) m_mode = M_APIN;
                end
            end
            M_OPEN: begin
                if (vehicle_arrival && vehicle_left) m_mode = M_ABLK;
                else if (vehicle_left) m_mode = M_IDLE;
            end
            M_APIN: if (rise && good) begin m_mode = M_OPEN; m_tries = 0; end
            M_ABLK: if (rise && good) m_mode = M_OPEN;
            default: m_mode = M_IDLE;
        endcase
        m_prev_ack = code_ack;
    endtask

    always @(negedge clk) begin
        chk("gate_open",   gate_open,   m_mode == M_OPEN);
        chk("gate_close",  gate_close,  m_mode != M_OPEN);
        chk("wrong_pin",   wrong_pin,   m_wp);
        chk("pin_alarm",   pin_alarm,   m_mode == M_APIN);
        chk("block_alarm", block_alarm, m_mode == M_ABLK);
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic press(input logic [15:0] c);
        code = c;
        code_ack = 1'b1;
        tick();
    endtask

    task automatic release_ack();
        code_ack = 1'b0;
        tick();
    endtask

    initial begin
        int pulses;

        // Normal pass
        rst = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("lit_reset_gate_close", gate_close, 1'b1);
        vehicle_arrival = 1'b1;
        tick();
        press(PIN);
        chk("lit_pass_open", gate_open, 1'b1);
        vehicle_arrival = 1'b0;
        vehicle_left = 1'b1;
        release_ack();
        chk("lit_pass_closed", gate_open, 1'b0);
        vehicle_left = 1'b0;

        // Two wrong codes then correct
        vehicle_arrival = 1'b1;
        tick();
        vehicle_arrival = 1'b0;
        press(16'h1234);
        chk("lit_wrong1_pulse", wrong_pin, 1'b1);
        release_ack();
        chk("lit_wrong1_end", wrong_pin, 1'b0);
        press(16'h1234);
        chk("lit_wrong2_pulse", wrong_pin, 1'b1);
        chk("lit_wrong2_noalarm", pin_alarm, 1'b0);
        release_ack();
        press(PIN);
        chk("lit_two_wrong_open", gate_open, 1'b1);
        release_ack();
        vehicle_left = 1'b1;
        tick();
        vehicle_left = 1'b0;

        // Three wrong codes -> alarm, wrong code keeps it, correct code clears
        vehicle_arrival = 1'b1;
        tick();
        vehicle_arrival = 1'b0;
        repeat (2) begin
            press(16'h0000);
            release_ack();
        end
        press(16'h0000);
        chk("lit_alarm_on_third", pin_alarm, 1'b1);
        release_ack();
        press(16'h1111);
        chk("lit_alarm_held", pin_alarm, 1'b1);
        chk("lit_alarm_no_wrong", wrong_pin, 1'b0);
        release_ack();
        press(PIN);
        chk("lit_alarm_cleared", pin_alarm, 1'b0);
        chk("lit_alarm_exit_open", gate_open, 1'b1);
        release_ack();

        // Block alarm from OPEN
        vehicle_arrival = 1'b1;
        vehicle_left = 1'b1;
        tick();
        chk("lit_block_on", block_alarm, 1'b1);
        chk("lit_block_gate_shut", gate_open, 1'b0);
        vehicle_arrival = 1'b0;
        vehicle_left = 1'b0;
        press(PIN);
        chk("lit_block_exit_open", gate_open, 1'b1);
        release_ack();
        vehicle_left = 1'b1;
        tick();
        vehicle_left = 1'b0;

        // Held acknowledge counts once; two more wrong codes must then reach the alarm
        vehicle_arrival = 1'b1;
        tick();
        vehicle_arrival = 1'b0;
        code = 16'hBEEF;
        code_ack = 1'b1;
        pulses = 0;
        repeat (25) begin
            tick();
            if (wrong_pin) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL held_ack_pulses actual=%0d expected=1", pulses);
        end
        release_ack();
        press(16'hBEEF);
        release_ack();
        chk("lit_held_count_one", pin_alarm, 1'b0);
        press(16'hBEEF);
        chk("lit_held_then_alarm", pin_alarm, 1'b1);

        // Asynchronous reset between edges while in ALARM_PIN
        #2;
        rst = 1'b0;
        #1;
        model_step();
        chk("lit_async_pin_alarm", pin_alarm, 1'b0);
        chk("lit_async_gate_close", gate_close, 1'b1);
        chk("lit_async_wrong_pin", wrong_pin, 1'b0);
        chk("lit_async_gate_open", gate_open, 1'b0);
        chk("lit_async_block", block_alarm, 1'b0);

        // Acknowledge already high across reset release must not count
        code = PIN;
        vehicle_arrival = 1'b1;
        tick();
        rst = 1'b1;
        repeat (4) tick();
        chk("lit_ack_held_over_reset", gate_open, 1'b0);
        code_ack = 1'b0;
        vehicle_arrival = 1'b0;
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            vehicle_arrival = ($urandom_range(0, 3) == 0);
            vehicle_left    = ($urandom_range(0, 3) == 0);
            code_ack        = $urandom_range(0, 1) == 1;
            code            = ($urandom_range(0, 2) == 0) ? PIN : 16'($urandom);
            rst             = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
